// File: rtl/memory_stage.sv
// MIPS MEM stage: word-addressed data memory with synchronous clear, plus the MEM/WB
// pipeline register with hazard-unit stall/flush and a sticky misalignment flag.
module memory_stage #(
  parameter int width = 31,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width:0]   M_ALU_out_M,
  input  logic [width:0]   M_write_data_M,
  input  logic             M_memWrite_M,
  input  logic             M_memRead_M,
  input  logic             M_memtoReg_M,
  input  logic             M_regWrite_M,
  input  logic [4:0]       M_writeReg_M,
  input  logic             M_stall_M,
  input  logic             M_flush_M,
  output logic [width:0]   W_read_data_W,
  output logic [width:0]   W_ALU_out_W,
  output logic             W_memtoReg_W,
  output logic             W_regWrite_W,
  output logic [4:0]       W_writeReg_W,
  output logic             M_misalign_err_M
);

  typedef struct packed {
    logic [width:0] rdata;
    logic [width:0] alu;
    logic           memtoreg;
    logic           regwrite;
    logic [4:0]     writereg;
  } memwb_t;

  logic [width:0] mem_q [DEPTH];
  logic [AW-1:0]  idx;
  logic [width:0] rdata;
  logic           misaligned;
  logic           we;
  memwb_t         memwb_q, memwb_d;
  logic           err_q, err_d;

  assign idx        = M_ALU_out_M[AW+1:2];
  assign misaligned = (|M_ALU_out_M[1:0]) & (M_memWrite_M | M_memRead_M);
  // Combinational read sees the pre-write word, giving old-data read-during-write.
  assign rdata      = mem_q[idx];
  assign we         = M_memWrite_M & ~M_stall_M & ~misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= M_write_data_M;
    end
  end

  always_comb begin
    memwb_d = memwb_q;
    if (M_flush_M) begin
      memwb_d = '0;
    end else if (!M_stall_M) begin
      memwb_d.rdata    = rdata;
      memwb_d.alu      = M_ALU_out_M;
      memwb_d.memtoreg = M_memtoReg_M;
      memwb_d.regwrite = M_regWrite_M;
      memwb_d.writereg = M_writeReg_M;
    end
  end

  // A stalled access is not yet committed, so it cannot raise the error.
  assign err_d = err_q | (misaligned & ~M_stall_M);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memwb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      memwb_q <= memwb_d;
      err_q   <= err_d;
    end
  end

  assign W_read_data_W    = memwb_q.rdata;
  assign W_ALU_out_W      = memwb_q.alu;
  assign W_memtoReg_W     = memwb_q.memtoreg;
  assign W_regWrite_W     = memwb_q.regwrite;
  assign W_writeReg_W     = memwb_q.writereg;
  assign M_misalign_err_M = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios then random traffic, all against a
// word-array reference model of the MEM stage.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu, wdata;
  logic        mw, mr, m2r, rw, stall, flush;
  logic [4:0]  wreg;
  logic [31:0] W_read_data_W, W_ALU_out_W;
  logic        W_memtoReg_W, W_regWrite_W, M_misalign_err_M;
  logic [4:0]  W_writeReg_W;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n),
    .M_ALU_out_M(alu), .M_write_data_M(wdata),
    .M_memWrite_M(mw), .M_memRead_M(mr), .M_memtoReg_M(m2r), .M_regWrite_M(rw),
    .M_writeReg_M(wreg), .M_stall_M(stall), .M_flush_M(flush),
    .W_read_data_W(W_read_data_W), .W_ALU_out_W(W_ALU_out_W),
    .W_memtoReg_W(W_memtoReg_W), .W_regWrite_W(W_regWrite_W),
    .W_writeReg_W(W_writeReg_W), .M_misalign_err_M(M_misalign_err_M)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mem_m [256];
  logic [31:0] e_rd, e_alu;
  logic        e_m2r, e_rw, e_err;
  logic [4:0]  e_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of M-stage inputs, advance the model, then compare every output.
  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                    input logic t, input logic g, input logic [4:0] rg,
                    input logic s, input logic f);
    int  word;
    bit  mis;
    alu = a; wdata = d; mw = w; mr = r; m2r = t; rw = g; wreg = rg; stall = s; flush = f;
    word = int'((a / 4) % 256);
    mis  = ((a % 4) != 0) && (w || r);
    if (!rst_n) begin
      foreach (mem_m[i]) mem_m[i] = 32'h0;
      e_rd = 0; e_alu = 0; e_m2r = 0; e_rw = 0; e_wr = 0; e_err = 0;
    end else begin
      if (f) begin
        e_rd = 0; e_alu = 0; e_m2r = 0; e_rw = 0; e_wr = 0;
      end else if (!s) begin
        e_rd = mem_m[word]; e_alu = a; e_m2r = t; e_rw = g; e_wr = rg;
      end
      if (w && !s && !mis) mem_m[word] = d;
      if (mis && !s) e_err = 1'b1;
    end
    @(posedge clk); #1;
    chk("read_data", W_read_data_W, e_rd);
    chk("alu_out",   W_ALU_out_W,   e_alu);
    chk("memtoreg",  {31'h0, W_memtoReg_W}, {31'h0, e_m2r});
    chk("regwrite",  {31'h0, W_regWrite_W}, {31'h0, e_rw});
    chk("writereg",  {27'h0, W_writeReg_W}, {27'h0, e_wr});
    chk("misalign",  {31'h0, M_misalign_err_M}, {31'h0, e_err});
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    op(a, d, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [4:0] rg);
    op(a, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, rg, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] held_rd, held_alu;
    rst_n = 1'b0;
    alu = 0; wdata = 0; mw = 0; mr = 0; m2r = 0; rw = 0; wreg = 0; stall = 0; flush = 0;
    foreach (mem_m[i]) mem_m[i] = 32'h0;
    // Reset state
    op(32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    op(32'h8, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    chk("reset_regwrite", {31'h0, W_regWrite_W}, 32'h0);
    rst_n = 1'b1;

    // 1: store then load
    st(32'h10, 32'hDEADBEEF);
    ld(32'h10, 5'd3);
    chk("t1_rdata", W_read_data_W, 32'hDEADBEEF);
    chk("t1_m2r",   {31'h0, W_memtoReg_W}, 32'h1);

    // 2: read-during-write returns old word
    st(32'h20, 32'h1);
    op(32'h20, 32'h2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    chk("t2_old", W_read_data_W, 32'h1);
    ld(32'h20, 5'd4);
    chk("t2_new", W_read_data_W, 32'h2);

    // 3: stall holds W and blocks the store
    held_rd = W_read_data_W; held_alu = W_ALU_out_W;
    repeat (3) op(32'h30, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    chk("t3_held_rd",  W_read_data_W, held_rd);
    chk("t3_held_alu", W_ALU_out_W, held_alu);
    ld(32'h30, 5'd6);
    chk("t3_blocked", W_read_data_W, 32'h0);
    st(32'h30, 32'h55);
    ld(32'h30, 5'd6);
    chk("t3_commit", W_read_data_W, 32'h55);

    // 4: flush beats stall
    op(32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1);
    chk("t4_rw", {31'h0, W_regWrite_W}, 32'h0);
    chk("t4_wr", {27'h0, W_writeReg_W}, 32'h0);
    // flush does not block a store
    op(32'h44, 32'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    ld(32'h44, 5'd1);
    chk("t4_store", W_read_data_W, 32'h99);

    // 5: misaligned store dropped, sticky error
    st(32'h13, 32'hAA);
    chk("t5_err", {31'h0, M_misalign_err_M}, 32'h1);
    ld(32'h10, 5'd2);
    chk("t5_unchanged", W_read_data_W, 32'hDEADBEEF);
    repeat (2) ld(32'h20, 5'd2);
    chk("t5_sticky", {31'h0, M_misalign_err_M}, 32'h1);

    // 6: address wrap, then reset mid-operation
    st(32'h400, 32'h77);
    ld(32'h0, 5'd8);
    chk("t6_wrap", W_read_data_W, 32'h77);
    rst_n = 1'b0;
    ld(32'h0, 5'd8);
    chk("t6_rst_rw",  {31'h0, W_regWrite_W}, 32'h0);
    chk("t6_rst_err", {31'h0, M_misalign_err_M}, 32'h0);
    rst_n = 1'b1;
    ld(32'h0, 5'd8);
    chk("t6_cleared", W_read_data_W, 32'h0);

    // Random traffic over a small window so addresses collide and wrap
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {22'h0, 10'($urandom_range(0, 1023))};
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) a = a + 32'h400;
      rst_n = ($urandom_range(0, 59) != 0);
      op(a, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         5'($urandom), ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
